// File: rtl/ir_multi.sv
// ir_multi: variable-length instruction register for SAP-2-class control units.
// Assembles 1..MAX_BYTES bus words into one instruction. It holds the opcode,
// the short operand and the little-endian extended operand for the controller.
module ir_multi #(
  parameter int WORD_W    = 8,
  parameter int OPC_W     = 4,
  parameter int MAX_BYTES = 3,
  parameter logic [2*(2**OPC_W)-1:0] LEN_MAP = 32'hFFAA_5555
) (
  input  logic                            CLK,
  input  logic                            CLR,
  input  logic [WORD_W-1:0]               D,
  input  logic                            Li_,
  input  logic                            Ei_,
  output logic [OPC_W-1:0]                opcode,
  output logic [WORD_W-OPC_W-1:0]         operand_lo,
  output logic [(MAX_BYTES-1)*WORD_W-1:0] operand_ext,
  output logic [1:0]                      ins_len,
  output logic                            busy,
  output logic                            ready,
  output logic                            ill,
  output logic [WORD_W-1:0]               bus_out
);

  localparam int LO_W  = WORD_W - OPC_W;
  localparam int EXT_W = (MAX_BYTES - 1) * WORD_W;
  localparam logic [1:0] MAX_CODE = 2'(MAX_BYTES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t             state_q;
  logic [1:0]         cnt_q;
  logic [OPC_W-1:0]   opcode_q;
  logic [LO_W-1:0]    lo_q;
  logic [EXT_W-1:0]   ext_q;
  logic [1:0]         len_q;
  logic               busy_q;
  logic               ready_q;
  logic               ill_q;

  logic [OPC_W-1:0]   opc_d;
  logic [1:0]         code_d;
  logic               ill_d;
  logic [1:0]         len_d;

  // Decode the length of an instruction whose first byte is on the bus.
  // An illegal length code is treated as a one-byte instruction so the
  // controller always gets a complete (flagged) instruction.
  always_comb begin
    opc_d  = D[WORD_W-1 -: OPC_W];
    code_d = LEN_MAP[{opc_d, 1'b0} +: 2];
    ill_d  = (code_d == 2'd0) || (code_d > MAX_CODE);
    len_d  = ill_d ? 2'd1 : code_d;
  end

  // Instruction assembly FSM with registered flags.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      opcode_q <= '0;
      lo_q     <= '0;
      ext_q    <= '0;
      len_q    <= 2'd0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, FULL: begin
          if (!Li_) begin
            opcode_q <= opc_d;
            lo_q     <= D[LO_W-1:0];
            ext_q    <= '0;
            len_q    <= len_d;
            ill_q    <= ill_d;
            if (len_d == 2'd1) begin
              state_q <= FULL;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              state_q <= COLLECT;
              cnt_q   <= 2'd1;
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
            end
          end
        end
        COLLECT: begin
          if (!Li_) begin
            for (int i = 0; i < MAX_BYTES - 1; i++) begin
              if (cnt_q == 2'(i + 1)) ext_q[i*WORD_W +: WORD_W] <= D;
            end
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q + 2'd1 == len_q) begin
              state_q <= FULL;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Operand drive toward the bus; the controller qualifies Ei_ with ready.
  always_comb begin
    bus_out = '0;
    if (!Ei_) begin
      if (len_q <= 2'd1) bus_out = {{OPC_W{1'b0}}, lo_q};
      else               bus_out = ext_q[WORD_W-1:0];
    end
  end

  assign opcode      = opcode_q;
  assign operand_lo  = lo_q;
  assign operand_ext = ext_q;
  assign ins_len     = len_q;
  assign busy        = busy_q;
  assign ready       = ready_q;
  assign ill         = ill_q;

endmodule

// File: tb/tb_ir_multi.sv
// Bench for ir_multi: directed scenarios plus randomized traffic, checked
// every cycle against a byte-count model of instruction assembly.
module tb_ir_multi;

  localparam int WORD_W    = 8;
  localparam int OPC_W     = 4;
  localparam int MAX_BYTES = 3;
  // Default map with opcode 5 made illegal (code 0).
  localparam logic [31:0] LMAP = 32'hFFAA_5155;

  logic        CLK = 1'b0;
  logic        CLR;
  logic [7:0]  D;
  logic        Li_;
  logic        Ei_;
  logic [3:0]  opcode;
  logic [3:0]  operand_lo;
  logic [15:0] operand_ext;
  logic [1:0]  ins_len;
  logic        busy;
  logic        ready;
  logic        ill;
  logic [7:0]  bus_out;

  ir_multi #(
    .WORD_W(WORD_W), .OPC_W(OPC_W), .MAX_BYTES(MAX_BYTES), .LEN_MAP(LMAP)
  ) dut (
    .CLK(CLK), .CLR(CLR), .D(D), .Li_(Li_), .Ei_(Ei_),
    .opcode(opcode), .operand_lo(operand_lo), .operand_ext(operand_ext),
    .ins_len(ins_len), .busy(busy), .ready(ready), .ill(ill), .bus_out(bus_out)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: an instruction is a length plus the number of bytes received.
  int         m_len = 0;
  int         m_got = 0;
  logic [3:0] m_opc = '0;
  logic [3:0] m_lo  = '0;
  logic [7:0] m_b [2] = '{8'h00, 8'h00};
  bit         m_ill = 1'b0;

  function automatic int len_code(input logic [3:0] opc);
    return int'((LMAP >> (2 * int'(opc))) & 32'd3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    int c;
    if (CLR) begin
      m_len = 0; m_got = 0; m_opc = '0; m_lo = '0;
      m_b[0] = '0; m_b[1] = '0; m_ill = 1'b0;
    end else if (!Li_) begin
      if (m_got < m_len) begin
        m_b[m_got-1] = D;
        m_got++;
      end else begin
        c      = len_code(D[7:4]);
        m_ill  = (c == 0) || (c > MAX_BYTES);
        m_len  = m_ill ? 1 : c;
        m_got  = 1;
        m_opc  = D[7:4];
        m_lo   = D[3:0];
        m_b[0] = '0;
        m_b[1] = '0;
      end
    end
  end

  always @(negedge CLK) begin
    logic [7:0] exp_bus;
    if (chk_en) begin
      if (Ei_)             exp_bus = 8'h00;
      else if (m_len <= 1) exp_bus = {4'h0, m_lo};
      else                 exp_bus = m_b[0];
      chk("m_opcode",  32'(opcode),      32'(m_opc));
      chk("m_lo",      32'(operand_lo),  32'(m_lo));
      chk("m_ext",     32'(operand_ext), 32'({m_b[1], m_b[0]}));
      chk("m_len",     32'(ins_len),     32'(m_len));
      chk("m_busy",    32'(busy),        32'(m_got < m_len));
      chk("m_ready",   32'(ready),       32'((m_len > 0) && (m_got == m_len)));
      chk("m_ill",     32'(ill),         32'(m_ill));
      chk("m_bus_out", 32'(bus_out),     32'(exp_bus));
    end
  end

  task automatic step(input bit clr, input bit li, input logic [7:0] d, input bit ei);
    @(posedge CLK);
    #2;
    CLR = clr;
    Li_ = li;
    D   = li ? 8'hxx : d;
    Ei_ = ei;
  endtask

  initial begin
    CLR = 1'b1; Li_ = 1'b0; D = 8'hFF; Ei_ = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_opcode", 32'(opcode),      0);
    chk("rst_lo",     32'(operand_lo),  0);
    chk("rst_ext",    32'(operand_ext), 0);
    chk("rst_len",    32'(ins_len),     0);
    chk("rst_flags",  32'({busy, ready, ill}), 0);
    chk("rst_bus",    32'(bus_out),     0);
    chk_en = 1'b1;

    // Single byte
    step(0, 0, 8'h1A, 1);
    step(0, 1, 8'h00, 0); #1;
    chk("sb_opcode", 32'(opcode), 1);
    chk("sb_lo",     32'(operand_lo), 32'hA);
    chk("sb_len",    32'(ins_len), 1);
    chk("sb_ready",  32'(ready), 1);
    chk("sb_bus",    32'(bus_out), 32'h0A);
    step(0, 1, 8'h00, 1); #1;
    chk("sb_bus_off", 32'(bus_out), 0);

    // Two bytes with two wait cycles
    step(0, 0, 8'h83, 1);
    step(0, 1, 8'h00, 1); #1;
    chk("tw_busy1",  32'({busy, ready}), 32'b10);
    step(0, 1, 8'h00, 1); #1;
    chk("tw_busy2",  32'({busy, ready}), 32'b10);
    step(0, 0, 8'h5C, 0);
    step(0, 1, 8'h00, 0); #1;
    chk("tw_ext",    32'(operand_ext), 32'h005C);
    chk("tw_len",    32'(ins_len), 2);
    chk("tw_bus",    32'(bus_out), 32'h5C);
    chk("tw_ready",  32'({busy, ready}), 32'b01);

    // Three bytes then back-to-back single byte
    step(0, 0, 8'hC0, 1);
    step(0, 0, 8'h34, 1);
    step(0, 0, 8'h12, 1);
    step(0, 0, 8'h2C, 1); #1;
    chk("th_ext",    32'(operand_ext), 32'h1234);
    chk("th_len",    32'(ins_len), 3);
    chk("th_ready",  32'(ready), 1);
    step(0, 1, 8'h00, 1); #1;
    chk("bb_opcode", 32'(opcode), 2);
    chk("bb_len",    32'(ins_len), 1);
    chk("bb_ext",    32'(operand_ext), 0);
    chk("bb_ready",  32'(ready), 1);

    // Reset mid-collect
    step(0, 0, 8'hC0, 1);
    step(0, 0, 8'h34, 1);
    step(1, 0, 8'hFF, 1);
    step(0, 1, 8'h00, 1); #1;
    chk("rm_all", 32'({opcode, operand_lo, ins_len, busy, ready, ill}), 0);
    chk("rm_ext", 32'(operand_ext), 0);
    step(0, 0, 8'h1B, 1);
    step(0, 1, 8'h00, 1); #1;
    chk("rm_len", 32'(ins_len), 1);
    chk("rm_lo",  32'(operand_lo), 32'hB);

    // Illegal length code
    step(0, 0, 8'h57, 1);
    step(0, 1, 8'h00, 1); #1;
    chk("il_flags", 32'({ill, ready, busy}), 32'b110);
    chk("il_len",   32'(ins_len), 1);
    step(0, 0, 8'h12, 1);
    step(0, 1, 8'h00, 1); #1;
    chk("il_clear", 32'(ill), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1),
           8'($urandom), ($urandom_range(0, 1) == 1));
    end
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 1);
    @(negedge CLK);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ir_multi.md
# ir_multi

Parametrised instruction register for SAP-2-class control units. It assembles variable-length instructions of 1 to MAX_BYTES bus words and presents the opcode, the short operand and the extended operand to the controller. A `ready` flag signals that a complete instruction is held. It replaces the fixed 8-bit opcode/operand IR when the instruction set grows beyond single-byte instructions.

## Interface
- `WORD_W`, default 8, width of the bus word and of each instruction byte.
- `OPC_W`, default 4, opcode width, taken from the MSBs of the first byte; must be < `WORD_W`.
- `MAX_BYTES`, default 3, maximum instruction length in words; legal range 2..3.
- `LEN_MAP`, default 32'hFFAA_5555, per-opcode length code, 2 bits per opcode.
  - Opcode n occupies bits [2n+1:2n]; width is 2*2^OPC_W.
  - Code 1..MAX_BYTES gives the length; code 0 or > MAX_BYTES is illegal.
- `CLK` in 1: single clock, rising edge.
- `CLR` in 1: reset; synchronous, active-high.
- `D` in WORD_W: instruction byte from the bus.
- `Li_` in 1: load strobe, active low; one byte is accepted per rising edge while low.
- `Ei_` in 1: operand output enable, active low.
- `opcode` out OPC_W: `byte0[WORD_W-1 -: OPC_W]`.
- `operand_lo` out WORD_W-OPC_W: `byte0[WORD_W-OPC_W-1:0]`.
- `operand_ext` out (MAX_BYTES-1)*WORD_W: extra bytes, little-endian; byte1 sits at [WORD_W-1:0].
- `ins_len` out 2: length of the held instruction; 0 when nothing has been loaded.
- `busy` out 1: collecting the extra bytes of an instruction.
- `ready` out 1: a complete instruction is held.
- `ill` out 1: the held instruction had an illegal length code.
- `bus_out` out WORD_W: operand drive toward the bus.

## Operation
- State machine: IDLE, COLLECT, FULL. Internal byte counter `cnt` is 2 bits wide.
- **Reset** (`CLR`=1 at an edge, overriding `Li_`):
  - State goes to IDLE and `cnt` to 0.
  - `opcode`, `operand_lo`, `operand_ext`, `ins_len`, `busy`, `ready` and `ill` all go to 0.
- **First-byte load**, in IDLE or FULL with `Li_`=0:
  - Capture `opcode` and `operand_lo` from `D`; clear `operand_ext` to 0.
  - `code = LEN_MAP[2*opcode_in +: 2]`.
  - If `code` is 0 or > MAX_BYTES: set `ins_len`=1 and `ill`=1; otherwise set `ins_len`=`code` and `ill`=0.
  - If `ins_len`=1, go to FULL. Otherwise go to COLLECT with `cnt`=1.
- **COLLECT**:
  - `Li_`=0: write `D` into `operand_ext[(cnt-1)*WORD_W +: WORD_W]` and increment `cnt`. When `cnt+1`=`ins_len`, go to FULL.
  - `Li_`=1: wait state; hold everything, with no limit on the number of wait cycles.
- **FULL**:
  - Hold the instruction.
  - `Li_`=0 overwrites it with a new first byte; no separate acknowledge is needed.
- **Flags**: `busy`=1 exactly in COLLECT; `ready`=1 exactly in FULL; both are registered.
- **`bus_out`** (combinational):
  - `Ei_`=1: 0.
  - `Ei_`=0 and `ins_len`≤1: `operand_lo`, zero-extended.
  - `Ei_`=0 and `ins_len`≥2: `operand_ext[WORD_W-1:0]`.
  - `bus_out` does not depend on `ready`; the controller gates `Ei_`.
- `D` carrying X/Z while `Li_`=1 must not affect state.

## Timing
- All state and registered outputs update on the rising `CLK` edge.
- `ready` rises at the edge that accepts the final byte, so it is visible in the following cycle.
  - Latency for an L-byte instruction with no wait states: L cycles from the first strobed edge.
- Back-to-back instructions: a first byte can be accepted in the cycle after `ready` rises; there are no bubbles.
- `CLR` mid-COLLECT discards the partial instruction in the same edge; the next `Li_`=0 starts a fresh instruction.

## Test plan
Default parameters unless stated otherwise.

- **Reset**: `CLR`=1 for 2 cycles with `Li_`=0 and `D`=8'hFF -> every output is 0 and the state is IDLE.
- **Single byte**: `D`=8'h1A with `Li_`=0 for one cycle, then `Ei_`=0 -> next cycle `opcode`=1, `operand_lo`=4'hA, `ins_len`=1, `ready`=1, `bus_out`=8'h0A; with `Ei_`=1, `bus_out`=0.
- **Two bytes with waits**: strobe 8'h83; then `Li_`=1 for 2 cycles; then strobe 8'h5C.
  - `busy`=1 during the waits and `ready`=0 until the second edge.
  - Then `operand_ext`=16'h005C, `ins_len`=2, `bus_out`=8'h5C.
- **Three bytes then back-to-back**: strobe 8'hC0, 8'h34, 8'h12 consecutively.
  - `operand_ext`=16'h1234, `ins_len`=3, `ready` after the third edge.
  - Next cycle strobe 8'h2C -> `opcode`=2, `ins_len`=1, `operand_ext`=0, `ready` stays 1.
- **Reset mid-collect**: strobe 8'hC0, then 8'h34, then `CLR`=1 for one edge -> all outputs 0. Then strobe 8'h1B -> `ins_len`=1, `operand_lo`=4'hB.
- **Illegal length**: `LEN_MAP` with opcode 5 mapped to code 0; strobe 8'h57 -> `ill`=1, `ins_len`=1, `ready`=1. A following legal opcode clears `ill`.
